// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
// Two-requester round-robin arbiter that drives the se/en controls of a
// downstream 2:1 tristate mux. A turnaround window (en=0) of DEAD_CYC cycles
// follows every grant release, so two sources never drive y at the same time.
// All outputs are registered. There are no combinational paths from inputs to outputs.
//
// Parameters:
//   DEAD_CYC  turnaround cycles after every release (1..15)
//   HOLD_MAX  maximum contended grant length (2..255), hold-limit build only
//
// Optional feature macro: MUX_ARB_HOLD_LIMIT_EN
//   When defined, an owner is forced off the bus after HOLD_MAX grant
//   cycles if the other side is requesting.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   req_a  in   source A requests the bus (level)
//   req_b  in   source B requests the bus (level)
//   gnt_a  out  A owns y this cycle
//   gnt_b  out  B owns y this cycle
//   se     out  mux select, 1 = a, 0 = b
//   en     out  mux enable, 1 = drive y, 0 = tristate
//   busy   out  arbiter is in any state other than IDLE

module mux_sel_arbiter #(
  parameter int DEAD_CYC = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic se,
  output logic en,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       last_b;
  logic [3:0] turn_cnt;
  logic       turn_done;
  logic       win_a;
  logic       win_b;
  logic       force_rel_a;
  logic       force_rel_b;

  // Round-robin winner: a lone requester wins; on a tie the side that was
  // not granted last wins (last_b=1 means B held the bus most recently).
  always_comb begin
    win_a = req_a & (~req_b | last_b);
    win_b = req_b & (~req_a | ~last_b);
  end

  assign turn_done = (turn_cnt == 4'(DEAD_CYC - 1));

`ifdef MUX_ARB_HOLD_LIMIT_EN
  logic [7:0] hold_cnt;
  logic       hold_sat;

  assign hold_sat    = (hold_cnt == 8'(HOLD_MAX - 1));
  assign force_rel_a = hold_sat & req_b;
  assign force_rel_b = hold_sat & req_a;

  // Grant-length counter. It clears whenever a grant starts and saturates,
  // so an uncontended owner re-checks the limit on every cycle after that.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= 8'd0;
    end else if ((state_nxt == GNT_A || state_nxt == GNT_B) && state_nxt != state) begin
      hold_cnt <= 8'd0;
    end else if ((state == GNT_A || state == GNT_B) && !hold_sat) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign force_rel_a = 1'b0;
  assign force_rel_b = 1'b0;
`endif

  // Next-state logic. Arbitration happens only in IDLE and on the final
  // TURN cycle. TURN is never shortened by incoming requests.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (win_a)      state_nxt = GNT_A;
        else if (win_b) state_nxt = GNT_B;
      end
      GNT_A: begin
        if (!req_a || force_rel_a) state_nxt = TURN;
      end
      GNT_B: begin
        if (!req_b || force_rel_b) state_nxt = TURN;
      end
      TURN: begin
        if (turn_done) begin
          if (win_a)      state_nxt = GNT_A;
          else if (win_b) state_nxt = GNT_B;
          else            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, bookkeeping and output registers. Outputs are decoded from the
  // next state so they become valid immediately after the deciding edge.
  // se is not driven in IDLE/TURN, so it keeps the last owner's value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      turn_cnt <= 4'd0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      se       <= 1'b0;
      en       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == TURN && state_nxt == TURN) begin
        turn_cnt <= turn_cnt + 4'd1;
      end else begin
        turn_cnt <= 4'd0;
      end

      if (state_nxt == GNT_A && state != GNT_A) begin
        last_b <= 1'b0;
      end else if (state_nxt == GNT_B && state != GNT_B) begin
        last_b <= 1'b1;
      end

      gnt_a <= (state_nxt == GNT_A);
      gnt_b <= (state_nxt == GNT_B);
      en    <= (state_nxt == GNT_A) || (state_nxt == GNT_B);
      busy  <= (state_nxt != IDLE);

      if (state_nxt == GNT_A) begin
        se <= 1'b1;
      end else if (state_nxt == GNT_B) begin
        se <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter
// Bench for mux_sel_arbiter. Two instances share clock, reset and requests:
// dut uses DEAD_CYC=1/HOLD_MAX=4, dut3 uses DEAD_CYC=3/HOLD_MAX=4.
// Output words are packed as {gnt_a, gnt_b, se, en, busy}.

module tb_mux_sel_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic req_a;
  logic req_b;

  logic gnt_a, gnt_b, se, en, busy;
  logic gnt_a3, gnt_b3, se3, en3, busy3;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic       ra;
    logic       rb;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[18];

  // Packed output patterns {gnt_a, gnt_b, se, en, busy}
  localparam logic [4:0] O_RST   = 5'b00000;
  localparam logic [4:0] O_A     = 5'b10111;
  localparam logic [4:0] O_B     = 5'b01011;
  localparam logic [4:0] O_TRN_A = 5'b00101;
  localparam logic [4:0] O_TRN_B = 5'b00001;
  localparam logic [4:0] O_IDL_A = 5'b00100;

  mux_sel_arbiter #(.DEAD_CYC(1), .HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req_a (req_a),
    .req_b (req_b),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b),
    .se    (se),
    .en    (en),
    .busy  (busy)
  );

  mux_sel_arbiter #(.DEAD_CYC(3), .HOLD_MAX(4)) dut3 (
    .clk   (clk),
    .rst   (rst),
    .req_a (req_a),
    .req_b (req_b),
    .gnt_a (gnt_a3),
    .gnt_b (gnt_b3),
    .se    (se3),
    .en    (en3),
    .busy  (busy3)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Drive inputs, then let one rising edge pass and settle before sampling
  task automatic applyStimulus(input logic r, input logic a, input logic b);
    rst   = r;
    req_a = a;
    req_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // en must equal gnt_a|gnt_b and both grants must never be high together
  task automatic checkInvariants(input string name, input logic ga, input logic gb, input logic e);
    checkOutput({name, "_en"}, {4'b0, e}, {4'b0, ga | gb});
    checkOutput({name, "_excl"}, {4'b0, ga & gb}, 5'b0);
  endtask

  // Expected dut output for edge i (1-based) of a continuous tie after reset
  function automatic logic [4:0] holdExpect(input int i);
`ifdef MUX_ARB_HOLD_LIMIT_EN
    int p;
    p = (i - 1) % 10;
    if (p < 4)       return O_A;
    else if (p == 4) return O_TRN_A;
    else if (p < 9)  return O_B;
    else             return O_TRN_B;
`else
    if (i > 0) return O_A;
    return O_RST;
`endif
  endfunction

  initial begin
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;

    // Table: reset, single requester, release, round robin, simultaneous
    // drop/raise, reset mid-grant, re-raise during TURN.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, O_RST};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, O_RST};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, O_A};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, O_A};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, O_TRN_A};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, O_IDL_A};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, O_B};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, O_TRN_B};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, O_A};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, O_TRN_A};
    vecs[10] = '{1'b0, 1'b0, 1'b1, O_B};
    vecs[11] = '{1'b1, 1'b0, 1'b1, O_RST};
    vecs[12] = '{1'b0, 1'b1, 1'b1, O_A};
    vecs[13] = '{1'b0, 1'b1, 1'b1, O_A};
    vecs[14] = '{1'b0, 1'b0, 1'b1, O_TRN_A};
    vecs[15] = '{1'b0, 1'b1, 1'b1, O_B};
    vecs[16] = '{1'b0, 1'b0, 1'b0, O_TRN_B};
    vecs[17] = '{1'b0, 1'b0, 1'b0, O_RST};

    #2;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ra, vecs[i].rb);
      checkOutput($sformatf("vec%0d", i), {gnt_a, gnt_b, se, en, busy}, vecs[i].exp);
      checkInvariants($sformatf("vec%0d", i), gnt_a, gnt_b, en);
    end

    // Turnaround length with DEAD_CYC=3: B waits while A drops.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("dead3_grant_a", {gnt_a3, gnt_b3, se3, en3, busy3}, O_A);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("dead3_hold_a", {gnt_a3, gnt_b3, se3, en3, busy3}, O_A);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("dead3_turn%0d", k), {gnt_a3, gnt_b3, se3, en3, busy3}, O_TRN_A);
      checkInvariants($sformatf("dead3_turn%0d", k), gnt_a3, gnt_b3, en3);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("dead3_grant_b", {gnt_a3, gnt_b3, se3, en3, busy3}, O_B);
    checkInvariants("dead3_grant_b", gnt_a3, gnt_b3, en3);

    // Continuous tie: alternation under the hold limit, or A forever without it.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput($sformatf("hold%0d", i), {gnt_a, gnt_b, se, en, busy}, holdExpect(i));
      checkInvariants($sformatf("hold%0d", i), gnt_a, gnt_b, en);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Two-requester round-robin arbiter that drives the `se` and `en` controls of the downstream 2:1 tristate mux (`mux_2to1`). It grants the shared output `y` to source A or source B, and holds the mux in high impedance (`en=0`) during idle and for a fixed number of turnaround cycles between owners, so two drivers never overlap. All outputs are registered.

## Interface
- `DEAD_CYC`, default 1: turnaround cycles with `en=0` after every grant release; legal range 1..15.
- `HOLD_MAX`, default 8: maximum consecutive grant cycles while the other side is requesting; legal range 2..255; used only with `MUX_ARB_HOLD_LIMIT_EN`.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req_a`  in  1  source A requests `y`; level, held while the source wants the bus.
- `req_b`  in  1  source B requests `y`.
- `gnt_a`  out  1  A owns `y` this cycle.
- `gnt_b`  out  1  B owns `y` this cycle.
- `se`  out  1  to mux `se`; 1 selects `a`, 0 selects `b`.
- `en`  out  1  to mux `en`; 1 drives `y`, 0 tristates it.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: `en=0`, no grant.
  - GNT_A: `gnt_a=1`, `se=1`, `en=1`.
  - GNT_B: `gnt_b=1`, `se=0`, `en=1`.
  - TURN: `en=0`, no grant, `se` holds its last value.
- Invariants:
  - `en == gnt_a | gnt_b`.
  - `gnt_a & gnt_b` is never 1.
- Arbitration happens in IDLE and on the final TURN cycle:
  - If only one side requests, that side wins.
  - If both request, the side not granted last (`last` register) wins.
- IDLE -> GNT_x when a winner exists; otherwise stay in IDLE.
- GNT_x -> TURN when its own request is low at the clock edge.
  - With the macro defined, also on a forced release (see Configuration).
- TURN lasts exactly `DEAD_CYC` cycles (`turn_cnt` counts 0..DEAD_CYC-1).
  - At the edge that ends TURN, go to GNT of the arbitration winner, or to IDLE if there are no requests.
- `last` updates on every entry to GNT_A or GNT_B.
- Requests that arrive during TURN are honoured at the end of TURN. TURN is never shortened.
- Simultaneous events:
  - Owner drops and other raises in the same cycle: go to TURN; the other side is granted after `DEAD_CYC` cycles.
  - Both sides request from IDLE: the round-robin tie-break decides.
- A requester that drops and re-raises its request during TURN competes normally.
  - When both sides request, round-robin gives the grant to the other side.
- Reset mid-grant: at the next edge, all outputs go to reset values. No turnaround is inserted. The downstream mux is tristated from that edge.

## Timing
- Reset values: state IDLE, `gnt_a=0`, `gnt_b=0`, `se=0`, `en=0`, `busy=0`, `last=B` (so A wins the first tie), all counters 0.
- Grant latency from IDLE: a request sampled at edge N gives grant, `se` and `en` valid after edge N (1 cycle).
- Release: own request low at edge K gives `en=0` after edge K.
  - The next grant is visible after edge K+DEAD_CYC.
  - `en` is low for exactly `DEAD_CYC` cycles when the other side is waiting.
- All outputs change only on rising `clk` edges. There are no combinational paths from inputs to outputs.

## Configuration
- `MUX_ARB_HOLD_LIMIT_EN` defined:
  - `hold_cnt` (8 bit) clears on GNT entry and increments each grant cycle, saturating at `HOLD_MAX-1`.
  - At an edge where `hold_cnt==HOLD_MAX-1` and the other side requests, the block forces TURN even if the owner still requests.
  - The owner therefore holds the grant for at most `HOLD_MAX` cycles while contended.
  - If uncontended at saturation, the check repeats every cycle; release follows one edge after the other side's request is sampled.
- Macro not defined: no `hold_cnt`, no forced release. The owner keeps the grant until it drops its request.

## Test plan
- Reset then single requester: `rst` for 2 cycles; `req_a` high from edge 3 -> after edge 3 `gnt_a=1`, `se=1`, `en=1`; all outputs 0 during reset.
- Tie from IDLE: `req_a` and `req_b` rise together -> A granted first. A drops, DEAD_CYC=1 -> one cycle with `en=0`, then `gnt_b=1`, `se=0`.
- Turnaround length: DEAD_CYC=3, B waiting, A drops at edge 10 -> `en=0` after edges 10..12, `gnt_b=1` after edge 13. Check `gnt_a & gnt_b` never 1.
- Hold limit (macro on, HOLD_MAX=4): both request continuously -> grants alternate A for 4 cycles, 1 turn cycle, B for 4 cycles, 1 turn cycle, and so on. With the macro off, A holds indefinitely.
- Reset mid-grant: `rst` asserted while `gnt_b=1` -> after that edge `gnt_b=0`, `en=0`, `se=0`, `busy=0`. After release, `last=B`, so A wins the next tie.
